// File: rtl/pong_pkg.sv
// Shared constants, state encoding and coordinate type for the pong game.
// All on-screen arithmetic is done in 11-bit signed so subtractions never wrap.
package pong_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int BALL_SIZE    = 8;
    localparam int PADDLE_W     = 8;
    localparam int PADDLE_H     = 64;
    localparam int PADDLE_L_X   = 16;
    localparam int PADDLE_R_X   = 616;
    localparam int BALL_SPEED   = 4;
    localparam int PADDLE_SPEED = 6;
    localparam int SERVE_FRAMES = 60;

    localparam int BALL_X0   = 316;
    localparam int BALL_Y0   = 236;
    localparam int PADDLE_Y0 = 208;

    typedef enum logic {
        SERVE = 1'b0,
        PLAY  = 1'b1
    } state_t;

    typedef logic signed [10:0] coord_t;

    localparam coord_t C_ZERO         = coord_t'(0);
    localparam coord_t C_H_ACTIVE     = coord_t'(H_ACTIVE);
    localparam coord_t C_V_ACTIVE     = coord_t'(V_ACTIVE);
    localparam coord_t C_BALL_SIZE    = coord_t'(BALL_SIZE);
    localparam coord_t C_PADDLE_W     = coord_t'(PADDLE_W);
    localparam coord_t C_PADDLE_H     = coord_t'(PADDLE_H);
    localparam coord_t C_BALL_SPEED   = coord_t'(BALL_SPEED);
    localparam coord_t C_PADDLE_SPEED = coord_t'(PADDLE_SPEED);
    localparam coord_t C_BALL_X0      = coord_t'(BALL_X0);
    localparam coord_t C_BALL_Y0      = coord_t'(BALL_Y0);
    localparam coord_t C_PADDLE_Y0    = coord_t'(PADDLE_Y0);
    localparam coord_t C_PADDLE_Y_MAX = coord_t'(V_ACTIVE - PADDLE_H);
    localparam coord_t C_BALL_Y_MAX   = coord_t'(V_ACTIVE - BALL_SIZE);
    localparam coord_t C_BALL_X_MAX   = coord_t'(H_ACTIVE - BALL_SIZE);
    localparam coord_t C_L_FACE       = coord_t'(PADDLE_L_X + PADDLE_W);
    localparam coord_t C_R_FACE       = coord_t'(PADDLE_R_X);

endpackage

// File: rtl/pong_paddle.sv
// One paddle: clamped y register stepped on frame_tick by level buttons.
// Hit flag is combinational from x/y; y updates one cycle after the tick.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int X_POS = PADDLE_L_X
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       up,
    input  logic       dn,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output coord_t     y_pos,
    output logic       in_paddle
);

    localparam coord_t C_X_LO = coord_t'(X_POS);
    localparam coord_t C_X_HI = coord_t'(X_POS + PADDLE_W);

    coord_t y_q, y_d, y_move, xs, ys;

    assign xs    = coord_t'({1'b0, x});
    assign ys    = coord_t'({1'b0, y});
    assign y_pos = y_q;

    always_comb begin
        y_d    = y_q;
        y_move = y_q;
        // Both buttons together cancel out.
        if (frame_tick && (up != dn)) begin
            if (up) begin
                y_move = y_q - C_PADDLE_SPEED;
                y_d    = (y_move < C_ZERO) ? C_ZERO : y_move;
            end else begin
                y_move = y_q + C_PADDLE_SPEED;
                y_d    = (y_move > C_PADDLE_Y_MAX) ? C_PADDLE_Y_MAX : y_move;
            end
        end
    end

    always_comb begin
        in_paddle = (xs >= C_X_LO) && (xs < C_X_HI) &&
                    (ys >= y_q) && (ys < y_q + C_PADDLE_H);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= C_PADDLE_Y0;
        end else begin
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/pong_game.sv
// Pong game state (serve/play FSM, ball, scores) advanced once per frame,
// plus a registered 1-bit pixel for the current x/y (1-cycle latency).
module pong_game
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    output logic       pong_pixel,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       serving
);

    state_t     state_q, state_d;
    logic [6:0] serve_cnt_q, serve_cnt_d;
    coord_t     ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic       dx_q, dx_d, dy_q, dy_d;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic       pixel_q, pixel_d;

    logic   frame_tick, in_l, in_r, in_ball;
    logic   ov_l, ov_r, hit_l, hit_r, miss_l, miss_r;
    logic   dy_next;
    coord_t pl_y, pr_y, xs, ys, y_next;

    assign xs         = coord_t'({1'b0, x});
    assign ys         = coord_t'({1'b0, y});
    assign frame_tick = (x == 10'd0) && (y == 10'(V_ACTIVE));

    pong_paddle #(.X_POS(PADDLE_L_X)) u_paddle_l (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .up         (btn_l_up),
        .dn         (btn_l_dn),
        .x          (x),
        .y          (y),
        .y_pos      (pl_y),
        .in_paddle  (in_l)
    );

    pong_paddle #(.X_POS(PADDLE_R_X)) u_paddle_r (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .up         (btn_r_up),
        .dn         (btn_r_dn),
        .x          (x),
        .y          (y),
        .y_pos      (pr_y),
        .in_paddle  (in_r)
    );

    always_comb begin
        in_ball = (xs >= ball_x_q) && (xs < ball_x_q + C_BALL_SIZE) &&
                  (ys >= ball_y_q) && (ys < ball_y_q + C_BALL_SIZE);
        ov_l    = (ball_y_q + C_BALL_SIZE > pl_y) && (ball_y_q < pl_y + C_PADDLE_H);
        ov_r    = (ball_y_q + C_BALL_SIZE > pr_y) && (ball_y_q < pr_y + C_PADDLE_H);
        hit_l   = !dx_q && (ball_x_q >= C_L_FACE) &&
                  (ball_x_q - C_BALL_SPEED <= C_L_FACE) && ov_l;
        hit_r   = dx_q && (ball_x_q + C_BALL_SIZE <= C_R_FACE) &&
                  (ball_x_q + C_BALL_SIZE + C_BALL_SPEED >= C_R_FACE) && ov_r;
        miss_l  = !dx_q && (ball_x_q < C_BALL_SPEED);
        miss_r  = dx_q && (ball_x_q + C_BALL_SPEED > C_BALL_X_MAX);
    end

    always_comb begin
        y_next  = ball_y_q;
        dy_next = dy_q;
        if (dy_q) begin
            if (ball_y_q + C_BALL_SPEED > C_BALL_Y_MAX) begin
                y_next  = C_BALL_Y_MAX;
                dy_next = 1'b0;
            end else begin
                y_next = ball_y_q + C_BALL_SPEED;
            end
        end else begin
            if (ball_y_q < C_BALL_SPEED) begin
                y_next  = C_ZERO;
                dy_next = 1'b1;
            end else begin
                y_next = ball_y_q - C_BALL_SPEED;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        pixel_d     = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE)) &&
                      (in_ball || in_l || in_r);

        if (frame_tick) begin
            if (state_q == SERVE) begin
                serve_cnt_d = serve_cnt_q - 7'd1;
                ball_x_d    = C_BALL_X0;
                ball_y_d    = C_BALL_Y0;
                if (serve_cnt_q == 7'd1) begin
                    state_d = PLAY;
                end
            end else if (miss_l || miss_r) begin
                // Re-serve toward whoever conceded; this tick's y motion is dropped.
                score_r_d   = score_r_q + {3'd0, miss_l};
                score_l_d   = score_l_q + {3'd0, miss_r};
                ball_x_d    = C_BALL_X0;
                ball_y_d    = C_BALL_Y0;
                dx_d        = miss_r;
                state_d     = SERVE;
                serve_cnt_d = 7'(SERVE_FRAMES);
            end else begin
                ball_y_d = y_next;
                dy_d     = dy_next;
                if (hit_l) begin
                    ball_x_d = C_L_FACE;
                    dx_d     = 1'b1;
                end else if (hit_r) begin
                    ball_x_d = C_R_FACE - C_BALL_SIZE;
                    dx_d     = 1'b0;
                end else begin
                    ball_x_d = dx_q ? (ball_x_q + C_BALL_SPEED) : (ball_x_q - C_BALL_SPEED);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SERVE;
            serve_cnt_q <= 7'(SERVE_FRAMES);
            ball_x_q    <= C_BALL_X0;
            ball_y_q    <= C_BALL_Y0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            pixel_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            pixel_q     <= pixel_d;
        end
    end

    assign pong_pixel = pixel_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign serving    = (state_q == SERVE);

endmodule

// File: tb/tb_pong_game.sv
// Bench for pong_game: a behavioural game model predicts pixels (queued, one
// cycle late) and scores/serving after every frame tick and reset.
module tb_pong_game;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
    logic       pong_pixel;
    logic [3:0] score_l, score_r;
    logic       serving;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];
    bit pend_state = 1'b0;

    int m_bx, m_by, m_ly, m_ry, m_cnt, m_sl, m_sr;
    bit m_dx, m_dy, m_play;

    pong_game dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .btn_l_up   (btn_l_up),
        .btn_l_dn   (btn_l_dn),
        .btn_r_up   (btn_r_up),
        .btn_r_dn   (btn_r_dn),
        .pong_pixel (pong_pixel),
        .score_l    (score_l),
        .score_r    (score_r),
        .serving    (serving)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit rb();
        return bit'($urandom_range(1, 0));
    endfunction

    task automatic model_reset();
        m_bx = 316; m_by = 236; m_dx = 1'b1; m_dy = 1'b1;
        m_ly = 208; m_ry = 208; m_cnt = 60; m_play = 1'b0;
        m_sl = 0; m_sr = 0;
    endtask

    function automatic int pmove(input int py, input bit up, input bit dn);
        if (up && !dn) return (py - 6 < 0) ? 0 : py - 6;
        if (dn && !up) return (py + 6 > 416) ? 416 : py + 6;
        return py;
    endfunction

    function automatic bit model_pix(input int px, input int py);
        if (px >= 640 || py >= 480) return 1'b0;
        return (px >= m_bx && px < m_bx + 8 && py >= m_by && py < m_by + 8) ||
               (px >= 16 && px < 24 && py >= m_ly && py < m_ly + 64) ||
               (px >= 616 && px < 624 && py >= m_ry && py < m_ry + 64);
    endfunction

    task automatic model_serve(input bit dir);
        m_bx = 316; m_by = 236; m_dx = dir; m_play = 1'b0; m_cnt = 60;
    endtask

    task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd);
        int ny;
        bit ndy;
        if (!m_play) begin
            if (m_cnt == 1) m_play = 1'b1;
            m_cnt--;
        end else begin
            ny = m_by; ndy = m_dy;
            if (m_dy) begin
                if (m_by + 4 > 472) begin ny = 472; ndy = 1'b0; end
                else ny = m_by + 4;
            end else begin
                if (m_by < 4) begin ny = 0; ndy = 1'b1; end
                else ny = m_by - 4;
            end
            if (!m_dx && m_bx >= 24 && m_bx - 4 <= 24 && m_by + 8 > m_ly && m_by < m_ly + 64) begin
                m_bx = 24; m_dx = 1'b1; m_by = ny; m_dy = ndy;
            end else if (m_dx && m_bx + 8 <= 616 && m_bx + 12 >= 616 &&
                         m_by + 8 > m_ry && m_by < m_ry + 64) begin
                m_bx = 608; m_dx = 1'b0; m_by = ny; m_dy = ndy;
            end else if (!m_dx && m_bx < 4) begin
                m_sr = (m_sr + 1) % 16;
                model_serve(1'b0);
            end else if (m_dx && m_bx + 4 > 632) begin
                m_sl = (m_sl + 1) % 16;
                model_serve(1'b1);
            end else begin
                m_bx = m_dx ? m_bx + 4 : m_bx - 4;
                m_by = ny; m_dy = ndy;
            end
        end
        m_ly = pmove(m_ly, lu, ld);
        m_ry = pmove(m_ry, ru, rd);
    endtask

    // One clock: check what the previous cycle produced, then drive the next inputs.
    task automatic step(input int sx, input int sy, input bit srst,
                        input bit lu, input bit ld, input bit ru, input bit rd);
        int px, py;
        px = sx & 1023;
        py = sy & 1023;
        @(negedge clk);
        if (exp_q.size() > 0) check("pixel", int'(pong_pixel), int'(exp_q.pop_front()));
        if (pend_state) begin
            check("score_l", int'(score_l), m_sl);
            check("score_r", int'(score_r), m_sr);
            check("serving", int'(serving), int'(!m_play));
            pend_state = 1'b0;
        end
        x = 10'(px); y = 10'(py); rst = srst;
        btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
        if (srst) begin
            model_reset();
            exp_q.push_back(1'b0);
            pend_state = 1'b1;
        end else begin
            exp_q.push_back(model_pix(px, py));
            if (px == 0 && py == 480) begin
                model_tick(lu, ld, ru, rd);
                pend_state = 1'b1;
            end
        end
    endtask

    task automatic probe(input int px, input int py);
        step(px, py, 1'b0, rb(), rb(), rb(), rb());
    endtask

    task automatic frame(input bit lu, input bit ld, input bit ru, input bit rd);
        step(0, 480, 1'b0, lu, ld, ru, rd);
        probe(m_bx, m_by);
        probe(m_bx + 7, m_by + 7);
        probe(m_bx + 8, m_by);
        probe(m_bx, m_by + 8);
        probe(m_bx - 1, m_by + 3);
        probe(16, m_ly);
        probe(23, m_ly - 1);
        probe(16, m_ly + 64);
        probe(616, m_ry + 63);
        probe(624, m_ry);
        probe(700, m_by);
        probe(1, 480);
        probe(0, 479);
    endtask

    function automatic bit [1:0] track(input int py);
        int target;
        target = m_by - 28;
        if (py > target + 2) return 2'b10;
        if (py < target - 2) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        bit [1:0] b;
        step(0, 0, 1'b1, 0, 0, 0, 0);
        step(316, 236, 1'b1, 0, 0, 0, 0);
        step(316, 236, 1'b0, 0, 0, 0, 0);
        step(315, 236, 1'b0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) frame(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) frame(1'b1, 1'b1, 1'b1, 1'b1);

        step(16, 0, 1'b0, 0, 0, 0, 0);
        step(316, 236, 1'b1, 0, 0, 0, 0);
        step(316, 236, 1'b0, 0, 0, 0, 0);
        step(16, 208, 1'b0, 0, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            b = track(m_ly);
            frame(b[1], b[0], 1'b0, 1'b0);
        end

        step(m_bx, m_by, 1'b0, 0, 0, 0, 0);
        step(m_bx, m_by, 1'b1, 0, 0, 0, 0);
        step(m_bx + 3, m_by + 3, 1'b0, 0, 0, 0, 0);

        for (int i = 0; i < 800; i++) begin
            b = track(m_ry);
            frame(1'b0, 1'b0, b[1], b[0]);
        end

        step(0, 0, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        if (exp_q.size() > 0) check("pixel", int'(pong_pixel), int'(exp_q.pop_front()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
